instruction_fetch_controller: RTL and testbench

Sequences the asynchronous-read instruction memory for the LEGv8 datapath. Holds the program counter and drives a registered, stable address to the memory for a configurable number of wait cycles to cover read delay. Captures the returned word and presents it to decode over a valid/ready handshake. Accepts branch redirects from the execute stage.

---
 rtl/instruction_fetch_controller.sv | 76 +++++++
 tb/tb_instruction_fetch_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer for the LEGv8 datapath.
// Holds a stable address for WAIT_CYCLES cycles, captures the word, hands it to decode.
module instruction_fetch_controller #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] ImemAddress,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        BranchTaken,
    input  logic [63:0] BranchTarget
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [63:0] PC0 = RESET_PC & ~64'h3;

    typedef enum logic {
        S_WAIT,
        S_VALID
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   pc;
    logic [63:0]   target;

    assign target      = BranchTarget & ~64'h3;
    assign ImemAddress = pc;

    // pc is the address register driven straight to memory
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc          <= PC0;
            state       <= S_WAIT;
            cnt         <= '0;
            InstrValid  <= 1'b0;
            Instruction <= 32'h0;
            InstrPC     <= 64'h0;
        end else if (BranchTaken) begin
            pc         <= target;
            cnt        <= '0;
            InstrValid <= 1'b0;
            state      <= S_WAIT;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (cnt == LAST) begin
                        Instruction <= ImemData;
                        InstrPC     <= pc;
                        InstrValid  <= 1'b1;
                        cnt         <= '0;
                        state       <= S_VALID;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_VALID: begin
                    if (InstrReady) begin
                        InstrValid <= 1'b0;
                        pc         <= pc + 64'd4;
                        cnt        <= '0;
                        state      <= S_WAIT;
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: transaction model plus scoreboard.
// Directed plan cases followed by randomized ready/redirect traffic.
module tb_instruction_fetch_controller;

    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] addr;
    logic [31:0] data;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic        valid;
    logic        rdy;
    logic        br;
    logic [63:0] tgt;

    logic [63:0] addr2;
    logic [31:0] data2;
    logic [31:0] instr2;
    logic [63:0] ipc2;
    logic        valid2;
    logic        rdy2 = 1'b1;
    logic        br2 = 1'b0;
    logic [63:0] tgt2 = 64'h0;

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] memf(input logic [63:0] a);
        case (a)
            64'h0:   memf = 32'h910003E1;
            64'h4:   memf = 32'h910007E2;
            64'h8:   memf = 32'h910003E3;
            64'hC:   memf = 32'h8B020021;
            default: memf = a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
        endcase
    endfunction

    assign data  = memf(addr);
    assign data2 = memf(addr2);

    instruction_fetch_controller #(.WAIT_CYCLES(W), .RESET_PC(64'h0)) dut (
        .CLK(CLK), .Reset(Reset), .ImemAddress(addr), .ImemData(data),
        .Instruction(instr), .InstrPC(ipc), .InstrValid(valid),
        .InstrReady(rdy), .BranchTaken(br), .BranchTarget(tgt)
    );

    instruction_fetch_controller #(
        .WAIT_CYCLES(1), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
    ) dut2 (
        .CLK(CLK), .Reset(Reset), .ImemAddress(addr2), .ImemData(data2),
        .Instruction(instr2), .InstrPC(ipc2), .InstrValid(valid2),
        .InstrReady(rdy2), .BranchTaken(br2), .BranchTarget(tgt2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: address age, held flag, delivery queue
    logic [63:0] m_pc;
    int          m_age;
    bit          m_hold;
    logic [95:0] q[$];
    logic [95:0] cur;
    bit          prev_valid;

    task automatic model_reset();
        m_pc = 64'h0;
        m_age = 0;
        m_hold = 1'b0;
        q.delete();
        prev_valid = 1'b0;
        cur = '0;
    endtask

    always @(posedge CLK) begin
        if (!Reset) begin
            if (br) begin
                m_hold = 1'b0;
                m_pc = {tgt[63:2], 2'b00};
                m_age = 0;
            end else if (m_hold) begin
                if (rdy) begin
                    m_hold = 1'b0;
                    m_pc = m_pc + 64'd4;
                    m_age = 0;
                end
            end else begin
                m_age++;
                if (m_age == W) begin
                    m_hold = 1'b1;
                    m_age = 0;
                    q.push_back({memf(m_pc), m_pc});
                end
            end
        end
    end

    // Monitor: pops one expected word per new delivery
    always @(negedge CLK) begin
        if (!Reset) begin
            chk("sb_valid", {63'h0, valid}, {63'h0, m_hold});
            chk("sb_addr", addr, m_pc);
            if (valid && !prev_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got delivery pc %h expected none", ipc);
                end else begin
                    cur = q.pop_front();
                end
            end
            if (valid) begin
                chk("sb_instr", {32'h0, instr}, {32'h0, cur[95:64]});
                chk("sb_pc", ipc, cur[63:0]);
            end
            prev_valid = valid;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v,
                           input logic [31:0] i, input logic [63:0] p);
        chk({nm, "_valid"}, {63'h0, valid}, {63'h0, v});
        chk({nm, "_instr"}, {32'h0, instr}, {32'h0, i});
        chk({nm, "_pc"}, ipc, p);
    endtask

    // Asserted mid-cycle so the clear is observed before any clock edge
    task automatic areset();
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", {63'h0, valid}, 64'h0);
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_pc", ipc, 64'h0);
        chk("rst_addr", addr, 64'h0);
        chk("rst_addr2", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("rst_valid2", {63'h0, valid2}, 64'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        rdy = 1'b0;
        br = 1'b0;
        tgt = 64'h0;
        model_reset();
        #1;
        chk_out("init", 1'b0, 32'h0, 64'h0);
        chk("init_addr", addr, 64'h0);
        tick();
        tick();
        Reset = 1'b0;

        // in-order stream with ready held high
        rdy = 1'b1;
        tick();
        chk("t1_e1_valid", {63'h0, valid}, 64'h0);
        tick();
        chk_out("t1_w0", 1'b1, 32'h910003E1, 64'h0);
        repeat (3) tick();
        chk_out("t1_w1", 1'b1, 32'h910007E2, 64'h4);
        repeat (3) tick();
        chk_out("t1_w2", 1'b1, 32'h910003E3, 64'h8);
        repeat (3) tick();
        chk_out("t1_w3", 1'b1, 32'h8B020021, 64'hC);

        // back-pressure
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out("t2_hold", 1'b1, 32'h8B020021, 64'hC);
            chk("t2_addr", addr, 64'hC);
        end
        rdy = 1'b1;
        tick();
        chk("t2_adv_addr", addr, 64'h10);
        chk("t2_adv_valid", {63'h0, valid}, 64'h0);

        // redirect while counter==1 fetching 0x008
        areset();
        repeat (7) tick();
        chk("t3_pre_addr", addr, 64'h8);
        chk("t3_pre_valid", {63'h0, valid}, 64'h0);
        br = 1'b1;
        tgt = 64'h00F;
        tick();
        br = 1'b0;
        chk("t3_nocap", {63'h0, valid}, 64'h0);
        chk("t3_addr", addr, 64'hC);
        repeat (2) tick();
        chk_out("t3_deliv", 1'b1, 32'h8B020021, 64'hC);

        // redirect coincident with handshake
        areset();
        rdy = 1'b0;
        repeat (2) tick();
        chk_out("t4_w0", 1'b1, 32'h910003E1, 64'h0);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        repeat (2) tick();
        chk_out("t4_w1", 1'b1, 32'h910007E2, 64'h4);
        rdy = 1'b1;
        br = 1'b1;
        tgt = 64'h0;
        tick();
        br = 1'b0;
        rdy = 1'b0;
        chk("t4_drop", {63'h0, valid}, 64'h0);
        chk("t4_addr", addr, 64'h0);
        repeat (2) tick();
        chk_out("t4_deliv", 1'b1, 32'h910003E1, 64'h0);

        // async reset while VALID, then mid-WAIT; wrap check on dut2
        areset();
        tick();
        chk("t6_wait_valid", {63'h0, valid}, 64'h0);
        areset();
        tick();
        chk("t5_valid2", {63'h0, valid2}, 64'h1);
        chk("t5_pc2", ipc2, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_instr2", {32'h0, instr2}, {32'h0, memf(64'hFFFF_FFFF_FFFF_FFFC)});
        chk("t6_e1_valid", {63'h0, valid}, 64'h0);
        tick();
        chk("t5_wrap_addr2", addr2, 64'h0);
        chk_out("t6_w0", 1'b1, 32'h910003E1, 64'h0);

        // randomized traffic, including targets near the top of memory
        areset();
        for (int k = 0; k < 3000; k++) begin
            rdy = ($urandom_range(0, 99) < 70);
            br = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0: tgt = {$urandom(), $urandom()};
                1: tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: tgt = 64'($urandom_range(0, 63));
            endcase
            tick();
        end
        br = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
